// File: rtl/decoder_chk_pkg.sv
// Shared types and defaults for the 3-to-8 decoder output checker.
package decoder_chk_pkg;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_NONE  = 2'b01,
    ERR_MULTI = 2'b10,
    ERR_FMIS  = 2'b11
  } err_t;

  typedef struct packed {
    logic [2:0] idx;
    logic       f;
    err_t       err;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Bit i is the expected f when line i is the asserted one (minterms 1, 3, 4, 6).
  localparam logic [7:0] F_MASK_DEFAULT = 8'b0101_1010;

endpackage

// File: rtl/decoder_output_checker_if.sv
// Sample input stream and classified-result output stream of the checker.
interface decoder_output_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] r1;
  logic [3:0] r2;
  logic       f;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_f;
  logic [1:0] out_err;

  modport master (
    output in_valid, r1, r2, f, out_ready,
    input  in_ready, out_valid, out_idx, out_f, out_err
  );

  modport slave (
    input  in_valid, r1, r2, f, out_ready,
    output in_ready, out_valid, out_idx, out_f, out_err
  );
endinterface

// File: rtl/chk_fifo.sv
// Small synchronous FIFO; pointers carry one extra bit to tell full from empty.
module chk_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the empty flag already marks its contents invalid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/decoder_output_checker.sv
// Classifies each active-low decoder sample, queues {idx, f, err} and keeps debug counters.
module decoder_output_checker
  import decoder_chk_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter int         CNT_W  = 16,
  parameter logic [7:0] F_MASK = F_MASK_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  decoder_output_checker_if.slave  bus,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     overflow
);

  logic [7:0]         lows;
  logic [3:0]         n_low;
  logic [2:0]         idx;
  err_t               err;
  entry_t             wr_entry;
  entry_t             head;
  logic [ENTRY_W-1:0] rdata;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch is inferred.
  always_comb begin
    lows  = ~{bus.r2, bus.r1};
    n_low = '0;
    idx   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (lows[i]) idx = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      n_low = n_low + 4'(lows[i]);
    end
    if (n_low == 4'd0)           err = ERR_NONE;
    else if (n_low > 4'd1)       err = ERR_MULTI;
    else if (bus.f != F_MASK[idx]) err = ERR_FMIS;
    else                         err = ERR_OK;
  end

  assign wr_entry = '{idx: idx, f: bus.f, err: err};
  assign push     = bus.in_valid && !full;
  assign pop      = !empty && bus.out_ready;

  chk_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Outputs read zero whenever the queue is empty, which also covers the reset state.
  assign head          = entry_t'(rdata);
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_idx   = empty ? 3'd0 : head.idx;
  assign bus.out_f     = empty ? 1'b0 : head.f;
  assign bus.out_err   = empty ? 2'd0 : head.err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      overflow   <= 1'b0;
    end else if (clr_cnt) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push && !(&sample_cnt))                 sample_cnt <= sample_cnt + 1'b1;
      if (push && err != ERR_OK && !(&err_cnt))   err_cnt    <= err_cnt + 1'b1;
      if (bus.in_valid && full)                   overflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_output_checker.sv
// Randomized and directed bench for decoder_output_checker against a queue-based reference model.
module tb_decoder_output_checker;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef struct {
    int idx;
    bit f;
    int err;
  } tb_entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_cnt = 1'b0;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic overflow;

  decoder_output_checker_if bus ();

  decoder_output_checker #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .F_MASK (8'b0101_1010)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_cnt    (clr_cnt),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  bit [7:0]  fm = 8'b0101_1010;
  tb_entry_t q[$];
  int        m_sc;
  int        m_ec;
  bit        m_ov;
  int        n_cmp = 0;
  int        n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference classification straight from the rules: count low lines, pick the first.
  function automatic tb_entry_t model_entry(input bit [7:0] ln, input bit fv);
    tb_entry_t e;
    int lows;
    int first;
    lows  = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (ln[i] == 1'b0) begin
        lows++;
        if (first < 0) first = i;
      end
    end
    e.f = fv;
    if (lows == 0) begin
      e.idx = 0; e.err = 1;
    end else if (lows > 1) begin
      e.idx = first; e.err = 2;
    end else begin
      e.idx = first; e.err = (fv != fm[first]) ? 3 : 0;
    end
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_sc = 0;
    m_ec = 0;
    m_ov = 0;
  endtask

  task automatic drive(input bit v, input bit [3:0] a1, input bit [3:0] a2, input bit fv,
                       input bit rdy, input bit clr = 1'b0);
    bus.in_valid  = v;
    bus.r1        = a1;
    bus.r2        = a2;
    bus.f         = fv;
    bus.out_ready = rdy;
    clr_cnt       = clr;
  endtask

  task automatic check_all();
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    if (q.size() > 0) begin
      check("out_idx", 32'(bus.out_idx), 32'(q[0].idx));
      check("out_f", 32'(bus.out_f), 32'(q[0].f));
      check("out_err", 32'(bus.out_err), 32'(q[0].err));
    end
    check("sample_cnt", 32'(sample_cnt), 32'(m_sc));
    check("err_cnt", 32'(err_cnt), 32'(m_ec));
    check("overflow", 32'(overflow), 32'(m_ov));
  endtask

  // One clock: decide model moves from pre-edge state, advance, then compare 1 time unit later.
  task automatic step();
    tb_entry_t e;
    bit do_push;
    bit do_pop;
    bit drop;
    do_push = bus.in_valid && (q.size() < DEPTH);
    do_pop  = bus.out_ready && (q.size() > 0);
    drop    = bus.in_valid && (q.size() >= DEPTH);
    e       = model_entry({bus.r2, bus.r1}, bus.f);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    if (clr_cnt) begin
      m_sc = 0; m_ec = 0; m_ov = 0;
    end else begin
      if (do_push && m_sc < CNT_MAX) m_sc++;
      if (do_push && e.err != 0 && m_ec < CNT_MAX) m_ec++;
      if (drop) m_ov = 1;
    end
    #1;
    check_all();
  endtask

  task automatic push_onehot(input int m, input bit fv, input bit rdy);
    bit [7:0] ln;
    ln = ~(8'd1 << m);
    drive(1'b1, ln[3:0], ln[7:4], fv, rdy);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] ln;
    int kind;
    int m;

    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_out_f", 32'(bus.out_f), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();

    // Correct decoder sweep over all eight minterms.
    for (int i = 0; i < 8; i++) begin
      push_onehot(i, fm[i], 1'b1);
      check("sweep_idx", 32'(bus.out_idx), 32'(i));
      check("sweep_f", 32'(bus.out_f), 32'(fm[i]));
      check("sweep_err", 32'(bus.out_err), 32'd0);
    end
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1);
    step();
    check("sweep_sample_cnt", 32'(sample_cnt), 32'd8);
    check("sweep_err_cnt", 32'(err_cnt), 32'd0);

    // Directed error classes.
    drive(1'b1, 4'hF, 4'hF, 1'b0, 1'b1); step();
    check("none_err", 32'(bus.out_err), 32'd1);
    check("none_idx", 32'(bus.out_idx), 32'd0);
    check("none_err_cnt", 32'(err_cnt), 32'd1);
    drive(1'b1, 4'b1100, 4'hF, 1'b0, 1'b1); step();
    check("multi_lo_err", 32'(bus.out_err), 32'd2);
    check("multi_lo_idx", 32'(bus.out_idx), 32'd0);
    drive(1'b1, 4'hF, 4'b0110, 1'b0, 1'b1); step();
    check("multi_hi_err", 32'(bus.out_err), 32'd2);
    check("multi_hi_idx", 32'(bus.out_idx), 32'd4);
    drive(1'b1, 4'b1101, 4'hF, 1'b0, 1'b1); step();
    check("fmis_err", 32'(bus.out_err), 32'd3);
    check("fmis_idx", 32'(bus.out_idx), 32'd1);
    drive(1'b1, 4'b1101, 4'hF, 1'b1, 1'b1); step();
    check("fok_err", 32'(bus.out_err), 32'd0);
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1); step();

    // Overflow: five samples into a stalled DEPTH=4 queue.
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1); step();
    for (int i = 0; i < 5; i++) begin
      push_onehot(i + 2, fm[i + 2], 1'b0);
      if (i == 3) check("full_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_sample_cnt", 32'(sample_cnt), 32'd4);
    check("ovf_head_idx", 32'(bus.out_idx), 32'd2);
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1); step();
    for (int i = 0; i < 4; i++) begin
      push_onehot(i, fm[i], 1'b1);
      check("pushpop_in_ready", 32'(bus.in_ready), 32'd1);
    end
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1);
    repeat (4) step();
    check("drained", 32'(bus.out_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Randomized traffic with back-pressure and occasional clears.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      m    = $urandom_range(0, 7);
      case (kind)
        0:       ln = ~(8'd1 << m);
        1:       ln = 8'hFF;
        2:       ln = 8'($urandom);
        default: ln = ~(8'd1 << m);
      endcase
      drive(1'($urandom_range(0, 3) != 0), ln[3:0], ln[7:4],
            (kind == 3) ? fm[m] : 1'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0));
      step();
    end
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1);
    repeat (DEPTH) step();

    // Counter saturation, then a clear that coincides with a push.
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1); step();
    drive(1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
    repeat (20) step();
    check("sat_sample_cnt", 32'(sample_cnt), 32'hF);
    check("sat_err_cnt", 32'(err_cnt), 32'hF);
    drive(1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1); step();
    check("clr_sample_cnt", 32'(sample_cnt), 32'd0);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_keeps_fifo", 32'(bus.out_valid), 32'd1);

    // Asynchronous reset in the middle of a stalled stream.
    for (int i = 0; i < 3; i++) push_onehot(i + 4, fm[i + 4], 1'b0);
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_sample_cnt", 32'(sample_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_onehot(6, fm[6], 1'b1);
    check("post_rst_idx", 32'(bus.out_idx), 32'd6);
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
